// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFun encodings, group field values and the
// arbiter FSM state type used by the sharing wrapper.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int FUN_W  = 6;

    localparam logic [FUN_W-1:0] ALU_ADD   = 6'b000000;
    localparam logic [FUN_W-1:0] ALU_SUB   = 6'b000001;
    localparam logic [FUN_W-1:0] ALU_AND   = 6'b011000;
    localparam logic [FUN_W-1:0] ALU_OR    = 6'b011110;
    localparam logic [FUN_W-1:0] ALU_XOR   = 6'b010110;
    localparam logic [FUN_W-1:0] ALU_NOR   = 6'b010001;
    localparam logic [FUN_W-1:0] ALU_PASSA = 6'b011010;
    localparam logic [FUN_W-1:0] ALU_SLL   = 6'b100000;
    localparam logic [FUN_W-1:0] ALU_SRL   = 6'b100001;
    localparam logic [FUN_W-1:0] ALU_SRA   = 6'b100011;
    localparam logic [FUN_W-1:0] ALU_EQ    = 6'b110011;
    localparam logic [FUN_W-1:0] ALU_NEQ   = 6'b110001;
    localparam logic [FUN_W-1:0] ALU_LT    = 6'b110101;
    localparam logic [FUN_W-1:0] ALU_LEZ   = 6'b111101;
    localparam logic [FUN_W-1:0] ALU_LTZ   = 6'b111011;
    localparam logic [FUN_W-1:0] ALU_GTZ   = 6'b111111;

    // ALUFun[5:4] selects the functional group inside the ALU.
    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [1:0] alu_group(input logic [FUN_W-1:0] fun);
        return fun[5:4];
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NUM_REQ.
module alu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               any_o,
    output logic [ID_W-1:0]    winner_o
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ:0]   seen;
    logic [NUM_REQ-1:0] first;
    logic [ID_W-1:0]    cand      [NUM_REQ];
    logic [ID_W-1:0]    win_chain [NUM_REQ+1];

    // Rotate so that bit 0 of rot is the requester ptr points at.
    assign rot          = NUM_REQ'({req_valid_i, req_valid_i} >> ptr_i);
    assign seen[0]      = 1'b0;
    assign win_chain[0] = '0;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
        logic [ID_W:0] sum;
        assign sum      = {1'b0, ptr_i} + (ID_W+1)'(gi);
        assign cand[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                      : sum[ID_W-1:0];
        assign first[gi]       = rot[gi] & ~seen[gi];
        assign seen[gi+1]      = seen[gi] | rot[gi];
        assign win_chain[gi+1] = win_chain[gi] | ({ID_W{first[gi]}} & cand[gi]);
    end

    assign any_o    = seen[NUM_REQ];
    assign winner_o = win_chain[NUM_REQ];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin
// accept, one EXEC cycle on registered operands, tagged response held until taken.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [32*NUM_REQ-1:0]   req_a_i,
    input  logic [32*NUM_REQ-1:0]   req_b_i,
    input  logic [6*NUM_REQ-1:0]    req_fun_i,
    input  logic [NUM_REQ-1:0]      req_sign_i,
    output logic [31:0]             alu_a_o,
    output logic [31:0]             alu_b_o,
    output logic [5:0]              alu_fun_o,
    output logic                    alu_sign_o,
    input  logic [31:0]             alu_out_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [31:0]             rsp_data_o,
    output logic                    busy_o
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    pend_id_q;
    logic [31:0]        alu_a_q, alu_b_q, rsp_data_q;
    logic [5:0]         alu_fun_q;
    logic               alu_sign_q, rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;

    logic               any;
    logic [ID_W-1:0]    winner;
    logic               window;
    logic               accept;
    logic [NUM_REQ-1:0] grant_vec;

    logic [31:0]        a_arr   [NUM_REQ];
    logic [31:0]        b_arr   [NUM_REQ];
    logic [5:0]         fun_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi]     = req_a_i[gi*32 +: 32];
        assign b_arr[gi]     = req_b_i[gi*32 +: 32];
        assign fun_arr[gi]   = req_fun_i[gi*6 +: 6];
        assign grant_vec[gi] = (winner == ID_W'(gi));
    end

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid_i (req_valid_i),
        .ptr_i       (ptr_q),
        .any_o       (any),
        .winner_o    (winner)
    );

    // A response handshake frees the datapath in the same cycle, so a new
    // operation can be accepted while the old result is being taken.
    assign window = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i);
    assign accept = window && any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = accept ? grant_vec : '0;
        busy_o      = (state_q != ST_IDLE);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            pend_id_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            alu_sign_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                alu_a_q    <= a_arr[winner];
                alu_b_q    <= b_arr[winner];
                alu_fun_q  <= fun_arr[winner];
                alu_sign_q <= req_sign_i[winner];
                pend_id_q  <= winner;
            end
            if (state_q == ST_EXEC) begin
                rsp_data_q  <= alu_out_i;
                rsp_id_q    <= pend_id_q;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == ST_RESP) && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_fun_o   = alu_fun_q;
    assign alu_sign_o  = alu_sign_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (ALUFun-encoded: add/sub, logic, shift, compare) between NUM_REQ requesters, e.g. the main pipeline and the branch/exception unit.
- Accepts operations through valid/ready request ports and round-robins between them.
- Drives the ALU from registered operands and returns each result, tagged with the requester id, on one valid/ready response channel.

Parameters:
NUM_REQ, 2, number of requesters (2..4 supported)
ID_W, 1, width of rsp_id; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept
req_a  in  32*NUM_REQ  DataA per requester, requester i at [32i+31:32i]
req_b  in  32*NUM_REQ  DataB per requester
req_fun  in  6*NUM_REQ  ALUFun per requester
req_sign  in  NUM_REQ  Sign per requester
alu_a  out  32  to ALU DataA
alu_b  out  32  to ALU DataB
alu_fun  out  6  to ALU ALUFun
alu_sign  out  1  to ALU Sign
alu_out  in  32  from ALU result
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_id  out  ID_W  index of the requester that owns the result
rsp_data  out  32  result
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, ptr=0.
  - alu_a, alu_b, alu_fun, alu_sign, rsp_data, rsp_id all 0.
  - rsp_valid=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- Accept window:
  - Open in IDLE, or in RESP in the same cycle that rsp_valid & rsp_ready.
  - Winner = first i with req_valid[i], scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - req_ready[winner]=1 only while the window is open; all other req_ready bits 0.
  - req_ready may depend combinationally on req_valid and rsp_ready. req_valid must never depend on req_ready.
- Accept (req_valid[i] & req_ready[i]):
  - Register req_a/b/fun/sign[i] into alu_a/b/fun/sign.
  - Register i into the pending id.
  - ptr <= (i+1) mod NUM_REQ.
  - Next state EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs stable from the operand registers.
  - Capture rsp_data <= alu_out and rsp_id <= pending id.
  - rsp_valid <= 1, next state RESP.
- RESP:
  - rsp_valid, rsp_data, rsp_id held stable until rsp_ready.
  - On handshake with a new accept in the same cycle: next state EXEC.
  - On handshake with no new accept: rsp_valid <= 0, next state IDLE.
  - Operand registers stay unchanged unless a new accept occurs.
- Latency: accept at cycle N, rsp_valid at N+2.
- Throughput: back-to-back 1 op per 2 cycles.
- ALUFun and Sign pass through opaquely; no decode or legality check. An unused encoding returns whatever the ALU produces.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1. A waiting requester is served within NUM_REQ accepts.
- ptr does not advance without an accept.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is dropped, no response is emitted, and ptr returns to 0.
- Operand width: all 32-bit, no truncation; rsp_data is alu_out verbatim.

Decomposition:
- Shared package alu_pkg:
  - ALUFun constants: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
  - Group field constants: ALUFun[5:4] = 00/01/10/11.
  - FSM state encoding.
- One sub-module alu_rr_pick: combinational round-robin picker. Inputs: req_valid, ptr. Outputs: any, winner index.

Test Plan:
- Reset: hold reset=0 with req_valid=all 1s -> after release, busy=0, rsp_valid=0, alu_* all 0; first accept goes to requester 0.
- Single op with real ALU attached: req0 a=5, b=7, fun=000000, sign=0 accepted at cycle N -> rsp_valid at N+2 with rsp_data=12, rsp_id=0. Repeat with req0 a=0xFFFFFFFF, b=1, fun=110101, sign=1 -> rsp_data=1.
- Contention: req0 a=10, b=3, SUB and req1 a=0xF0F0, b=0x0FF0, AND, both held valid, rsp_ready=1 -> rsp_id sequence 0,1,0,1 with data 7, 0x00F0, 7, 0x00F0; one response every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, req_ready=0, alu_* unchanged; rsp_ready=1 -> handshake plus a simultaneous accept of the next request.
- Reset mid-op: accept req1 SLL (a=4, b=1), assert reset during EXEC -> rsp_valid never rises for it; after release, ptr=0, so with both valid the grant goes to 0.
- Idle hold: no req_valid for 10 cycles after a response -> state IDLE, busy=0, ptr unchanged, rsp_valid=0.
